// File: rtl/reg_dump_pkg.sv
// Shared types and defaults for the register-file dump reader.
// REG_DUMP_SKIP_ZERO_EN: when defined, the walk skips hardwired-zero register 0.
package reg_dump_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StSend,
        StDone
    } state_e;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefAddrWidth = 5;
    localparam int unsigned DefNumRegs   = 32;

`ifdef REG_DUMP_SKIP_ZERO_EN
    localparam int unsigned FirstIdx = 1;
`else
    localparam int unsigned FirstIdx = 0;
`endif

endpackage

// File: rtl/reg_dump_reader.sv
// Walks every architectural register through a spare read port and streams (addr, data)
// pairs over valid/ready. REG_DUMP_SKIP_ZERO_EN (see reg_dump_pkg) skips register 0.
module reg_dump_reader
    import reg_dump_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned NUM_REGS   = DefNumRegs
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic [ADDR_WIDTH-1:0] raddr_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [ADDR_WIDTH-1:0] FirstIdxW = ADDR_WIDTH'(FirstIdx);
    localparam logic [ADDR_WIDTH-1:0] LastIdx   = ADDR_WIDTH'(NUM_REGS - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  accept;

    assign accept = (state_q == StSend) && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                // abort wins over a simultaneous start
                if (start_i && !abort_i) begin
                    state_d = StRead;
                end
            end
            StRead: state_d = abort_i ? StDone : StSend;
            StSend: begin
                if (abort_i) begin
                    state_d = StDone;
                end else if (accept) begin
                    state_d = (idx_q == LastIdx) ? StDone : StRead;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        idx_d      = idx_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        if (state_q == StIdle) begin
            idx_d = FirstIdxW;
        end
        if (state_q == StRead) begin
            out_addr_d = idx_q;
            out_data_d = rdata_i;
        end
        if (accept && (idx_q != LastIdx)) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q      <= FirstIdxW;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            idx_q      <= idx_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        busy_o      = (state_q == StRead) || (state_q == StSend);
        raddr_o     = busy_o ? idx_q : '0;
        out_valid_o = (state_q == StSend);
        done_o      = (state_q == StDone);
        out_addr_o  = out_addr_q;
        out_data_o  = out_data_q;
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: full dumps, stalls, write coherence, abort and reset.
// Honours REG_DUMP_SKIP_ZERO_EN for expected first index, pair count and dump length.
module tb_reg_dump_reader;

`ifdef REG_DUMP_SKIP_ZERO_EN
    localparam int First = 1;
`else
    localparam int First = 0;
`endif
    localparam int NPairs    = 32 - First;
    localparam int ExpCycles = 2 * NPairs + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        ready = 1'b1;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic        out_valid;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;

    logic        load = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rf [32];
    logic [31:0] mdl [32];

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;
    int          got_addr [$];
    logic [31:0] got_data [$];
    logic        stall_prev = 1'b0;
    logic [4:0]  addr_prev = '0;
    logic [31:0] data_prev = '0;

    always #5 clk = ~clk;

    reg_dump_reader dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .abort_i     (abort),
        .raddr_o     (raddr),
        .rdata_i     (rdata),
        .out_valid_o (out_valid),
        .out_ready_i (ready),
        .out_addr_o  (out_addr),
        .out_data_o  (out_data),
        .busy_o      (busy),
        .done_o      (done)
    );

    // Register file stand-in: combinational read, write lands on posedge.
    assign rdata = rf[raddr];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= (i == 0) ? 32'h0 : 32'h1000_0000 + i;
            end
        end else if (wr_en) begin
            rf[wr_addr] <= wr_data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sample mid-cycle: records accepted pairs and checks hold during stalls.
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev && out_valid) begin
                check_eq("stall_hold_addr", {27'b0, out_addr}, {27'b0, addr_prev});
                check_eq("stall_hold_data", out_data, data_prev);
            end
            if (out_valid && ready) begin
                got_addr.push_back(int'(out_addr));
                got_data.push_back(out_data);
            end
            if (done) done_cnt++;
        end
        stall_prev <= out_valid && !ready && !rst;
        addr_prev  <= out_addr;
        data_prev  <= out_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_got();
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic init_model();
        for (int i = 0; i < 32; i++) begin
            mdl[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + i;
        end
    endtask

    task automatic reload_rf();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // mode 0: ready high; mode 1: coherence writes to r5/r6; mode 2: ready 3-on/3-off
    task automatic run_dump(input int mode, output int cyc);
        bit seen;
        cyc   = 0;
        seen  = 0;
        start = 1'b1;
        while (cyc < 400 && !seen) begin
            wr_en = 1'b0;
            if (mode == 1 && cyc == 2 * (5 - First) + 1) begin
                wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
            end
            if (mode == 1 && cyc == 2 * (6 - First)) begin
                wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'hDEAD_BEEF;
            end
            if (mode == 2) ready = ((cyc / 3) % 2) == 0;
            tick();
            cyc++;
            start = 1'b0;
            if (done) seen = 1;
        end
        wr_en = 1'b0;
        ready = 1'b1;
        check_eq("done_seen", {31'b0, seen}, 32'd1);
    endtask

    task automatic verify_pairs(input string name, input int n_exp);
        check_eq({name, "_cnt"}, got_addr.size(), n_exp);
        for (int i = 0; i < n_exp && i < got_addr.size(); i++) begin
            check_eq($sformatf("%s_addr%0d", name, i), got_addr[i], First + i);
            check_eq($sformatf("%s_data%0d", name, i), got_data[i], mdl[First + i]);
        end
    endtask

    task automatic check_all_zero(input string name);
        check_eq({name, "_raddr"}, {27'b0, raddr}, 32'd0);
        check_eq({name, "_valid"}, {31'b0, out_valid}, 32'd0);
        check_eq({name, "_addr"}, {27'b0, out_addr}, 32'd0);
        check_eq({name, "_data"}, out_data, 32'd0);
        check_eq({name, "_busy"}, {31'b0, busy}, 32'd0);
        check_eq({name, "_done"}, {31'b0, done}, 32'd0);
    endtask

    task automatic wait_valid_addr(input int a, input string name);
        int n = 0;
        while (!(out_valid && out_addr == a) && n < 200) begin
            tick();
            n++;
        end
        check_eq({name, "_reached"}, {31'b0, (out_valid && out_addr == a)}, 32'd1);
    endtask

    initial begin
        int cyc;
        int dcnt;
        init_model();
        rst = 1'b1;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Full dump, ready tied high
        clear_got();
        dcnt = done_cnt;
        run_dump(0, cyc);
        check_eq("full_cycles", cyc, ExpCycles);
        tick();
        check_eq("full_busy_after", {31'b0, busy}, 32'd0);
        check_eq("full_done_after", {31'b0, done}, 32'd0);
        check_eq("full_done_pulses", done_cnt - dcnt, 1);
        verify_pairs("full", NPairs);

        // start and abort together in idle: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_eq("sa_busy", {31'b0, busy}, 32'd0);
        tick();
        check_eq("sa_busy2", {31'b0, busy}, 32'd0);
        check_eq("sa_done", {31'b0, done}, 32'd0);

        // Backpressure: ready toggles every 3 cycles
        clear_got();
        run_dump(2, cyc);
        tick();
        verify_pairs("stall", NPairs);

        // Write coherence on r5 (same edge) and r6 (one cycle earlier)
        clear_got();
        run_dump(1, cyc);
        tick();
        mdl[6] = 32'hDEAD_BEEF;
        verify_pairs("coh", NPairs);
        check_eq("coh_r5_old", got_data.size() > 5 - First ? got_data[5 - First] : 32'hX,
                 32'h1000_0005);
        init_model();
        reload_rf();

        // Abort during SEND of idx 10 while that pair is accepted
        clear_got();
        dcnt  = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid_addr(10, "abort");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_done", {31'b0, done}, 32'd1);
        check_eq("abort_valid", {31'b0, out_valid}, 32'd0);
        check_eq("abort_busy", {31'b0, busy}, 32'd0);
        tick();
        check_eq("abort_done_off", {31'b0, done}, 32'd0);
        check_eq("abort_idle_busy", {31'b0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check_eq("abort_done_pulses", done_cnt - dcnt, 1);
        verify_pairs("abort", 11 - First);

        // Reset mid-dump at idx 7
        clear_got();
        dcnt  = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid_addr(7, "rst");
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        tick();
        tick();
        check_eq("midrst_no_done", done_cnt - dcnt, 0);
        clear_got();
        run_dump(0, cyc);
        check_eq("restart_cycles", cyc, ExpCycles);
        tick();
        verify_pairs("restart", NPairs);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
